// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath types: coefficient width, 8x8 block layout,
// saturation bounds and the dequantizer state encoding.
package jpeg_pkg;

    localparam int COEF_W   = 11;
    localparam int BLOCK_N  = 8;
    localparam int COEF_MAX = 1023;
    localparam int COEF_MIN = -1024;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [BLOCK_N-1:0][BLOCK_N-1:0] coef_blk_t;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        HOLD
    } deq_state_e;

endpackage

// File: rtl/dequant_sat_mul.sv
// Registered coefficient x quantizer-step multiply followed by a saturate
// stage back to coefficient width; index and valid ride along with the data.
module dequant_sat_mul
    import jpeg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld,
    input  logic [5:0]               idx,
    input  logic signed [COEF_W-1:0] coef,
    input  logic [7:0]               q,
    output logic                     res_vld,
    output logic [5:0]               res_idx,
    output logic signed [COEF_W-1:0] res,
    output logic                     res_sat
);

    // 11-bit signed x 9-bit (zero-extended) step: |product| < 2^18 always fits.
    localparam int PROD_W = 19;
    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(COEF_MAX);
    localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(COEF_MIN);

    function automatic logic signed [COEF_W-1:0] sat_val(input logic signed [PROD_W-1:0] x);
        if (x > SAT_HI)
            return COEF_W'(COEF_MAX);
        else if (x < SAT_LO)
            return COEF_W'(COEF_MIN);
        else
            return x[COEF_W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [PROD_W-1:0] x);
        return (x > SAT_HI) || (x < SAT_LO);
    endfunction

    logic signed [PROD_W-1:0] coef_x;
    logic signed [PROD_W-1:0] q_x;
    logic signed [PROD_W-1:0] prod_full;
    logic signed [PROD_W-1:0] prod_p1;
    logic [5:0]               idx_p1;
    logic                     vld_p1;

    assign coef_x    = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
    assign q_x       = {{(PROD_W-8){1'b0}}, q};
    assign prod_full = coef_x * q_x;

    // ---- stage boundary: product register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld;
    end

    always_ff @(posedge clk) begin
        if (vld) begin
            prod_p1 <= prod_full;
            idx_p1  <= idx;
        end
    end

    // ---- stage boundary: saturate, consumed by the caller's result register ----
    assign res_vld = vld_p1;
    assign res_idx = idx_p1;
    assign res     = sat_val(prod_p1);
    assign res_sat = is_sat(prod_p1);

endmodule

// File: rtl/cr_dequantizer.sv
// Cr dequantizer: serial row-major coefficients in, scaled by Q_MATRIX and
// saturated, presented as a parallel 8x8 block with valid/ready on both sides.
module cr_dequantizer
    import jpeg_pkg::*;
#(
    parameter int Q_MATRIX [BLOCK_N][BLOCK_N] = '{default: 1}
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    output coef_blk_t                Z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag
);

    deq_state_e state;
    deq_state_e state_nxt;
    logic [5:0] k;
    logic [1:0] drain_cnt;
    logic       accept;
    logic       last_accept;
    logic       sat_int;

    logic                     vld_p0;
    logic [5:0]               k_p0;
    logic signed [COEF_W-1:0] coef_p0;
    logic [7:0]               q_p0;

    logic                     res_vld;
    logic [5:0]               res_idx;
    logic signed [COEF_W-1:0] res;
    logic                     res_sat;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (k == 6'd63);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (last_accept) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd1) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // in_ready stays low while rst is held so nothing is taken during reset.
    always_comb begin
        in_ready  = (state == FILL) && !rst;
        out_valid = (state == HOLD);
        sat_flag  = (state == HOLD) && sat_int;
    end

    // k wraps 63 -> 0 naturally; only accepted coefficients advance it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept)
                k <= k + 6'd1;
            if (last_accept)
                drain_cnt <= 2'd2;
            else if (state == DRAIN)
                drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // ---- stage boundary p0: accepted coefficient and its index ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            coef_p0 <= in_coef;
            k_p0    <= k;
        end
    end

    assign q_p0 = 8'(Q_MATRIX[k_p0[5:3]][k_p0[2:0]]);

    dequant_sat_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld_p0),
        .idx     (k_p0),
        .coef    (coef_p0),
        .q       (q_p0),
        .res_vld (res_vld),
        .res_idx (res_idx),
        .res     (res),
        .res_sat (res_sat)
    );

    // ---- stage boundary p2: block buffer write and block-level saturation flag ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Z       <= '0;
            sat_int <= 1'b0;
        end else begin
            if (res_vld)
                Z[res_idx[5:3]][res_idx[2:0]] <= res;
            if ((state == HOLD) && out_ready)
                sat_int <= 1'b0;
            else if (res_vld && res_sat)
                sat_int <= 1'b1;
        end
    end

endmodule

// File: doc/cr_dequantizer.md
Name: cr_dequantizer

Overview:
Inverse of the Cr quantizer stage, used by the decode/verification path. It accepts quantized Cr coefficients serially, one per handshake, in row-major order: index k = 8*i + j. Each coefficient is multiplied by Q_MATRIX[i][j] and saturated to 11-bit signed. The results are assembled into a parallel 8x8 block that matches the layout of the DCT-coefficient arrays used by the quantizers. Flow control is valid/ready on both sides, so it can sit between an entropy decoder and an IDCT.

Parameters:
- Q_MATRIX, default '{default: 1}, int[8][8] quantization table; each entry is an integer in 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_coef is valid this cycle.
- in_ready  out  1  block can accept a coefficient this cycle.
- in_coef  in  11 signed  quantized coefficient for index k.
- Z  out  [8][8] x 11 signed  dequantized coefficient block.
- out_valid  out  1  Z holds a complete block.
- out_ready  in  1  consumer accepts Z this cycle.
- sat_flag  out  1  at least one coefficient in the presented block saturated; qualified by out_valid.

Behaviour:
- Reset (async, rst=1):
  - state=FILL, k=0, drain counter=0.
  - out_valid=0, sat_flag=0, all Z=0.
  - in_ready=1 once rst is released.
  - Pipeline valid bits are cleared.
- Accept: a coefficient is accepted on any rising edge with in_valid && in_ready. k counts accepted coefficients only; bubbles on in_valid do not advance it.
- Pipeline, coefficient accepted at edge t:
  - Edge t: in_coef, its index k and a valid bit are registered (stage 1).
  - Edge t+1: the 19-bit signed product in_coef * Q_MATRIX[k/8][k%8] is registered (stage 2).
  - Edge t+2: the product is saturated to [-1024, 1023] and written to the Z buffer entry [k/8][k%8] (stage 3). If clamping occurred, sat_flag_int is set.
- Arithmetic: the multiply is exact, with no rounding. Q is zero-extended to 9 bits before the signed multiply.
- FSM states: FILL, DRAIN, HOLD.
  - FILL: in_ready=1. On the accept with k=63, go to DRAIN and set drain counter=2; k wraps to 0.
  - DRAIN: in_ready=0. Drain counter decrements each edge; when it reaches 0, go to HOLD. Latency: out_valid rises 2 edges after the last accept.
  - HOLD: in_ready=0, out_valid=1, sat_flag=sat_flag_int. Z and sat_flag are stable while out_valid && !out_ready. On an edge with out_ready=1, go to FILL, out_valid=0 and clear sat_flag_int.
- Z is not cleared between blocks; every entry is overwritten by the next block.
- out_ready while not in HOLD is ignored.
- Throughput: at best one block every 67 cycles (64 accepts + 2 drain + 1 handshake). There is no overlap of fill and hold.
- Reset mid-block discards the partial block. The next block starts at k=0.

Decomposition:
- Package jpeg_pkg holds:
  - COEF_W=11 and BLOCK_N=8.
  - typedef coef_t (logic signed [10:0]) and typedef coef_blk_t (coef_t [8][8]).
  - Constants COEF_MAX=1023 and COEF_MIN=-1024.
  - typedef deq_state_e {FILL, DRAIN, HOLD}.
- One sub-module: dequant_sat_mul. It is the registered coef x Q multiply plus the saturate stage, with a valid passthrough. It is reusable by future y_dequantizer and cb_dequantizer blocks.

Test Plan:
1. Ramp, Q all 1: feed in_coef = k-32 for k=0..63 back-to-back from edge 0.
   - Expect out_valid after edge 65, Z[i][j] = 8i+j-32, sat_flag=0.
   - Expect in_ready=0 from edge 64 until the handshake.
2. Scaling, Q all 16, all inputs 50 except k=9 at -3.
   - Expect Z=800 everywhere except Z[1][1]=-48, sat_flag=0.
3. Saturation, Q all 255, k=0 input 100, k=1 input -100, rest 0.
   - Expect Z[0][0]=1023, Z[0][1]=-1024, other Z=0, sat_flag=1.
   - The next clean block then reports sat_flag=0.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
   - Expect Z and sat_flag stable, in_ready=0.
   - Raise out_ready for one cycle: next cycle out_valid=0, in_ready=1.
5. Bubbles: random in_valid gaps, including single-cycle gaps before k=63, with Q ramp Q[i][j]=i+j+1.
   - Expect results identical to the gap-free run; out_valid 2 edges after the last accept.
6. Reset mid-operation: assert rst after 30 accepts, and separately during HOLD.
   - Expect out_valid=0, Z=0, in_ready=1 after release.
   - Expect the following full block to match the golden values exactly.
